matrix_skew_feeder: RTL and testbench

- Sits directly downstream of the dual-port matrix data BRAM (16 x 32-bit, bidirectional dual port).
- Owns the BRAM's second port and reads two 4x4 int8 operand matrices (A and B) into local registers.
- Replays them as diagonally skewed streams: A rows enter the systolic array's west edge, B columns enter its north edge.
- The Nios keeps port 1 for loading and updating matrix data; this block never writes.

---
 rtl/matrix_skew_feeder.sv | 180 ++++++++++++++++++
 tb/tb_matrix_skew_feeder.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_skew_feeder.sv
// rtl/matrix_skew_feeder.sv - loads A/B operand matrices from BRAM port 2 and replays them as skewed systolic feeds
module matrix_skew_feeder #(
    parameter int N      = 4,
    parameter int ADDR_W = 4,
    parameter int A_BASE = 0,
    parameter int B_BASE = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_address,
    output logic              bram_chipselect,
    output logic              bram_clken,
    output logic              bram_write,
    output logic [3:0]        bram_byteenable,
    output logic [31:0]       bram_writedata,
    input  logic [31:0]       bram_readdata,
    input  logic              feed_ready,
    output logic              feed_valid,
    output logic              feed_last,
    output logic [N*8-1:0]    a_west,
    output logic [N*8-1:0]    b_north
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED, S_DONE} state_t;

    localparam logic [3:0] LAST_T = 4'(3*N-2);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_rd_cnt;
    logic [3:0]        r_t;
    logic [N*32-1:0]   r_a_mat;
    logic [N*32-1:0]   r_b_mat;
    logic [N*8-1:0]    r_a_west;
    logic [N*8-1:0]    r_b_north;
    logic              w_accept;
    logic [2:0]        w_row;
    logic [3:0]        w_t_next;
    logic [2*N*8-1:0]  w_beat_next;

    // Lane i of the west feed carries A[i][t-i]; lane j of the north feed carries B[t-j][j].
    function automatic logic [2*N*8-1:0] f_beat(input logic [3:0] t,
                                                input logic [N*32-1:0] am,
                                                input logic [N*32-1:0] bm);
        logic [N*8-1:0] a;
        logic [N*8-1:0] b;
        int k;
        a = '0;
        b = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(t) - i;
            if (k >= 0 && k < N) begin
                a[8*i +: 8] = am[32*i + 8*k +: 8];
                b[8*i +: 8] = bm[32*k + 8*i +: 8];
            end
        end
        return {a, b};
    endfunction

    assign bram_write      = 1'b0;
    assign bram_byteenable = 4'hF;
    assign bram_writedata  = '0;
    assign a_west          = r_a_west;
    assign b_north         = r_b_north;

    assign w_accept    = (r_state == S_FEED) && feed_ready;
    assign w_row       = 3'(r_rd_cnt - 4'd1);
    // Entering FEED needs beat 0, which only touches row 0 of each matrix, so the
    // B row 3 still being captured on that edge does not matter.
    assign w_t_next    = (r_state == S_FEED) ? r_t + 4'd1 : 4'd0;
    assign w_beat_next = f_beat(w_t_next, r_a_mat, r_b_mat);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and control outputs.
    always_comb begin
        w_next          = r_state;
        busy            = 1'b0;
        done            = 1'b0;
        bram_chipselect = 1'b0;
        bram_clken      = 1'b0;
        bram_address    = '0;
        feed_valid      = 1'b0;
        feed_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (r_rd_cnt < 4'd8) begin
                    bram_chipselect = 1'b1;
                    bram_clken      = 1'b1;
                    bram_address    = (r_rd_cnt < 4'd4)
                                    ? ADDR_W'(A_BASE) + ADDR_W'(r_rd_cnt)
                                    : ADDR_W'(B_BASE) + ADDR_W'(r_rd_cnt - 4'd4);
                end else begin
                    w_next = S_FEED;
                end
            end
            S_FEED: begin
                busy       = 1'b1;
                feed_valid = 1'b1;
                feed_last  = (r_t == LAST_T);
                if (w_accept && r_t == LAST_T) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Read counter, matrix capture, beat counter and registered feed lanes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_cnt  <= '0;
            r_t       <= '0;
            r_a_mat   <= '0;
            r_b_mat   <= '0;
            r_a_west  <= '0;
            r_b_north <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rd_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    r_rd_cnt <= r_rd_cnt + 4'd1;
                    if (r_rd_cnt != 4'd0) begin
                        if (!w_row[2]) begin
                            r_a_mat[32*w_row[1:0] +: 32] <= bram_readdata;
                        end else begin
                            r_b_mat[32*w_row[1:0] +: 32] <= bram_readdata;
                        end
                    end
                    if (r_rd_cnt == 4'd8) begin
                        r_t                    <= '0;
                        {r_a_west, r_b_north}  <= w_beat_next;
                    end
                end
                S_FEED: begin
                    if (w_accept) begin
                        if (r_t == LAST_T) begin
                            r_t       <= '0;
                            r_a_west  <= '0;
                            r_b_north <= '0;
                        end else begin
                            r_t                   <= r_t + 4'd1;
                            {r_a_west, r_b_north} <= w_beat_next;
                        end
                    end
                end
                default: begin
                    r_a_west  <= '0;
                    r_b_north <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// tb/tb_matrix_skew_feeder.sv - directed self-checking bench for matrix_skew_feeder
module tb_matrix_skew_feeder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  bram_address;
    logic        bram_chipselect;
    logic        bram_clken;
    logic        bram_write;
    logic [3:0]  bram_byteenable;
    logic [31:0] bram_writedata;
    logic [31:0] bram_readdata;
    logic        feed_ready;
    logic        feed_valid;
    logic        feed_last;
    logic [31:0] a_west;
    logic [31:0] b_north;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] mem [0:15];
    logic [3:0]  r_addr2 = 4'd0;
    logic [31:0] ea [0:3];
    logic [31:0] eb [0:3];

    logic [31:0] got_a    [0:31];
    logic [31:0] got_b    [0:31];
    logic        got_last [0:31];
    logic [3:0]  got_addr [0:31];
    logic        got_cs   [0:31];
    int n_beats, done_cycle, first_valid, n_done, hold_bad;
    logic [31:0] stall_a, stall_b;

    always #5 clk = ~clk;

    // BRAM port 2: registered address, unregistered read data.
    always @(posedge clk) begin
        if (bram_chipselect && bram_clken) r_addr2 <= bram_address;
    end
    assign bram_readdata = mem[r_addr2];

    matrix_skew_feeder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .bram_address(bram_address), .bram_chipselect(bram_chipselect),
        .bram_clken(bram_clken), .bram_write(bram_write),
        .bram_byteenable(bram_byteenable), .bram_writedata(bram_writedata),
        .bram_readdata(bram_readdata), .feed_ready(feed_ready),
        .feed_valid(feed_valid), .feed_last(feed_last),
        .a_west(a_west), .b_north(b_north)
    );

    function automatic logic [31:0] exp_a(input int t);
        logic [31:0] r;
        int k;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            k = t - i;
            if (k >= 0 && k < 4) r[8*i +: 8] = ea[i][8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_b(input int t);
        logic [31:0] r;
        int k;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            k = t - j;
            if (k >= 0 && k < 4) r[8*j +: 8] = eb[k][8*j +: 8];
        end
        return r;
    endfunction

    // Runs one start-to-idle stream, recording beats, addresses and done timing.
    // Cycle 0 drives start; the LOAD state therefore begins in cycle 1.
    task automatic run_stream(input int stall_at, input int stall_len, input int s1,
                              input int s2, input int s3, input int wr_cyc,
                              input logic [31:0] wr_data);
        int  stall_cnt;
        int  post;
        logic rdy;
        n_beats = 0; done_cycle = -1; first_valid = -1; n_done = 0; hold_bad = 0;
        stall_cnt = 0; post = 0;
        for (int c = 0; c < 200 && post < 25; c++) begin
            @(negedge clk);
            start = (c == 0 || c == s1 || c == s2 || c == s3);
            if (c == wr_cyc) mem[0] = wr_data;
            if (c < 32) begin
                got_addr[c] = bram_address;
                got_cs[c]   = bram_chipselect & bram_clken;
            end
            if (done) begin
                n_done++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (done_cycle >= 0) post++;
            if (feed_valid && first_valid < 0) first_valid = c;
            rdy = !(feed_valid && n_beats == stall_at && stall_cnt < stall_len);
            if (!rdy) begin
                if (stall_cnt == 0) begin
                    stall_a = a_west;
                    stall_b = b_north;
                end else if (a_west !== stall_a || b_north !== stall_b) begin
                    hold_bad++;
                end
                stall_cnt++;
            end
            feed_ready = rdy;
            if (feed_valid && rdy && n_beats < 32) begin
                got_a[n_beats]    = a_west;
                got_b[n_beats]    = b_north;
                got_last[n_beats] = feed_last;
                n_beats++;
            end
        end
        start      = 1'b0;
        feed_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; feed_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, done, feed_valid, feed_last, bram_chipselect, bram_clken, bram_write} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {busy, done, feed_valid, feed_last, bram_chipselect, bram_clken, bram_write});
        end
        n_total++;
        if ({bram_address, a_west, b_north, bram_writedata} !== 100'b0) begin
            n_bad++;
            $display("FAIL reset_data addr=%h a=%h b=%h wd=%h want all 0",
                     bram_address, a_west, b_north, bram_writedata);
        end
        n_total++;
        if (bram_byteenable !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_byteenable got=%h want=f", bram_byteenable);
        end
        start = 1'b0; reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy, feed_valid, bram_chipselect} !== 3'b0) begin
            n_bad++;
            $display("FAIL reset_release_idle got=%b want=000", {busy, feed_valid, bram_chipselect});
        end
    endtask

    task automatic test_basic();
        run_stream(-1, 0, -1, -1, -1, -1, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            n_total++;
            if (got_addr[c] !== 4'(c - 1) || got_cs[c] !== 1'b1) begin
                n_bad++;
                $display("FAIL basic_addr c=%0d got=%h cs=%b want=%h cs=1", c, got_addr[c], got_cs[c], c - 1);
            end
        end
        n_total++;
        if (got_cs[9] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_cs_off got=%b want=0", got_cs[9]);
        end
        n_total++;
        if (first_valid != 10) begin
            n_bad++;
            $display("FAIL basic_first_valid got=%0d want=10", first_valid);
        end
        n_total++;
        if (n_beats != 11 || done_cycle != 21 || n_done != 1) begin
            n_bad++;
            $display("FAIL basic_done beats=%0d done_cyc=%0d ndone=%0d want 11 21 1", n_beats, done_cycle, n_done);
        end
        n_total++;
        if (got_a[0] !== 32'h00000001 || got_b[0] !== 32'h00000011) begin
            n_bad++;
            $display("FAIL basic_beat0 a=%h b=%h want 00000001 00000011", got_a[0], got_b[0]);
        end
        n_total++;
        if (got_a[1] !== 32'h00000502 || got_b[1] !== 32'h00001215) begin
            n_bad++;
            $display("FAIL basic_beat1 a=%h b=%h want 00000502 00001215", got_a[1], got_b[1]);
        end
        n_total++;
        if (got_a[3] !== 32'h0D0A0704 || got_b[3] !== 32'h14171A1D) begin
            n_bad++;
            $display("FAIL basic_beat3 a=%h b=%h want 0d0a0704 14171a1d", got_a[3], got_b[3]);
        end
        n_total++;
        if (got_a[6] !== 32'h10000000 || got_b[6] !== 32'h20000000) begin
            n_bad++;
            $display("FAIL basic_beat6 a=%h b=%h want 10000000 20000000", got_a[6], got_b[6]);
        end
        n_total++;
        if (got_a[10] !== 32'h0 || got_b[10] !== 32'h0 || got_last[10] !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_beat10 a=%h b=%h last=%b want 0 0 1", got_a[10], got_b[10], got_last[10]);
        end
        for (int t = 0; t < 11; t++) begin
            n_total++;
            if (got_a[t] !== exp_a(t) || got_b[t] !== exp_b(t) || got_last[t] !== (t == 10)) begin
                n_bad++;
                $display("FAIL basic_stream t=%0d a=%h b=%h last=%b want %h %h %b",
                         t, got_a[t], got_b[t], got_last[t], exp_a(t), exp_b(t), t == 10);
            end
        end
    endtask

    task automatic test_backpressure();
        run_stream(4, 5, -1, -1, -1, -1, 32'h0);
        n_total++;
        if (hold_bad != 0 || stall_a !== exp_a(4) || stall_b !== exp_b(4)) begin
            n_bad++;
            $display("FAIL bp_hold bad=%0d a=%h b=%h want 0 %h %h", hold_bad, stall_a, stall_b, exp_a(4), exp_b(4));
        end
        n_total++;
        if (n_beats != 11 || done_cycle != 26 || n_done != 1) begin
            n_bad++;
            $display("FAIL bp_done beats=%0d done_cyc=%0d ndone=%0d want 11 26 1", n_beats, done_cycle, n_done);
        end
        for (int t = 0; t < 11; t++) begin
            n_total++;
            if (got_a[t] !== exp_a(t) || got_b[t] !== exp_b(t)) begin
                n_bad++;
                $display("FAIL bp_stream t=%0d a=%h b=%h want %h %h", t, got_a[t], got_b[t], exp_a(t), exp_b(t));
            end
        end
    endtask

    task automatic test_ignored_start();
        run_stream(-1, 0, 3, 14, 21, -1, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            n_total++;
            if (got_addr[c] !== 4'(c - 1)) begin
                n_bad++;
                $display("FAIL ign_addr c=%0d got=%h want=%h", c, got_addr[c], c - 1);
            end
        end
        n_total++;
        if (n_beats != 11 || done_cycle != 21 || n_done != 1) begin
            n_bad++;
            $display("FAIL ign_done beats=%0d done_cyc=%0d ndone=%0d want 11 21 1", n_beats, done_cycle, n_done);
        end
        n_total++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ign_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int  nb;
        bit  hit;
        bit  saw_done;
        nb = 0; hit = 0; saw_done = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clk);
            start = (c == 0);
            feed_ready = 1'b1;
            if (feed_valid) begin
                if (nb == 6) hit = 1;
                else nb++;
            end
        end
        start = 1'b0;
        n_total++;
        if (!hit || a_west !== exp_a(6) || b_north !== exp_b(6)) begin
            n_bad++;
            $display("FAIL mrst_beat6 reached=%0d a=%h b=%h want 1 %h %h", hit, a_west, b_north, exp_a(6), exp_b(6));
        end
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, feed_valid, feed_last, bram_chipselect, bram_clken} !== 6'b0 ||
            a_west !== 32'h0 || b_north !== 32'h0 || bram_address !== 4'h0) begin
            n_bad++;
            $display("FAIL mrst_async ctrl=%b a=%h b=%h addr=%h want all 0",
                     {busy, done, feed_valid, feed_last, bram_chipselect, bram_clken}, a_west, b_north, bram_address);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        n_total++;
        if (saw_done) begin
            n_bad++;
            $display("FAIL mrst_no_done got=1 want=0");
        end
        run_stream(-1, 0, -1, -1, -1, -1, 32'h0);
        n_total++;
        if (n_beats != 11 || done_cycle != 21 || n_done != 1) begin
            n_bad++;
            $display("FAIL mrst_restart beats=%0d done_cyc=%0d ndone=%0d want 11 21 1", n_beats, done_cycle, n_done);
        end
        for (int t = 0; t < 11; t++) begin
            n_total++;
            if (got_a[t] !== exp_a(t) || got_b[t] !== exp_b(t)) begin
                n_bad++;
                $display("FAIL mrst_stream t=%0d a=%h b=%h want %h %h", t, got_a[t], got_b[t], exp_a(t), exp_b(t));
            end
        end
    endtask

    task automatic test_port_indep();
        run_stream(-1, 0, -1, -1, -1, 12, 32'hA4A3A2A1);
        for (int t = 0; t < 11; t++) begin
            n_total++;
            if (got_a[t] !== exp_a(t) || got_b[t] !== exp_b(t)) begin
                n_bad++;
                $display("FAIL pind_old t=%0d a=%h b=%h want %h %h", t, got_a[t], got_b[t], exp_a(t), exp_b(t));
            end
        end
        ea[0] = 32'hA4A3A2A1;
        run_stream(-1, 0, -1, -1, -1, -1, 32'h0);
        n_total++;
        if (got_a[0] !== 32'h000000A1 || got_a[3] !== 32'h0D0A07A4) begin
            n_bad++;
            $display("FAIL pind_new_hand a0=%h a3=%h want 000000a1 0d0a07a4", got_a[0], got_a[3]);
        end
        for (int t = 0; t < 11; t++) begin
            n_total++;
            if (got_a[t] !== exp_a(t) || got_b[t] !== exp_b(t)) begin
                n_bad++;
                $display("FAIL pind_new t=%0d a=%h b=%h want %h %h", t, got_a[t], got_b[t], exp_a(t), exp_b(t));
            end
        end
    endtask

    initial begin
        ea[0] = 32'h04030201; ea[1] = 32'h08070605; ea[2] = 32'h0C0B0A09; ea[3] = 32'h100F0E0D;
        eb[0] = 32'h14131211; eb[1] = 32'h18171615; eb[2] = 32'h1C1B1A19; eb[3] = 32'h201F1E1D;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mem[i]     = ea[i];
            mem[i + 4] = eb[i];
        end
        reset_n = 1'b0; start = 1'b0; feed_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_start();
        test_mid_reset();
        test_port_indep();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
